seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit is selected (1 kHz digit rate at 50 MHz); legal range >= 2.
REQ-002 Parameter BLANK_CYC, default 500, anti-ghost cycles at the start of each digit slot during which all anodes are off; legal range 0 to SCAN_DIV-1.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle strobe that captures val_a/val_b for display.
REQ-006 val_a  input  7  road A countdown, binary.
REQ-007 val_b  input  7  road B countdown, binary.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 seg  output  7  segment drive, order abcdefg, active-low (0 = lit).
REQ-010 an  output  4  digit anodes, active-low: an[0]=A units, an[1]=A tens, an[2]=B units, an[3]=B tens.

Function
REQ-011 Values above 99 shall be saturated to 99 when captured.
REQ-012 Conversion FSM states: IDLE, CONV, COMMIT. In IDLE, load=1 at edge k captures both saturated values into remainder registers, clears the tens registers and enters CONV.
REQ-013 CONV shall last exactly 10 cycles; in each cycle, for each channel independently, if remainder >= 10 then remainder -= 10 and tens += 1. At the 10th CONV edge (k+10) the FSM enters COMMIT.
REQ-014 At edge k+11 COMMIT shall copy both channels' tens and units (remainder) into the display registers in the same cycle and return to IDLE; display registers never show a partial result.
REQ-015 busy = (state != IDLE); high for exactly 11 cycles following the load edge.
REQ-016 load while busy shall restart conversion from the new values (CONV counter reset to 0); the old pending result is discarded.
REQ-017 Scan prescaler counts 0..SCAN_DIV-1 and wraps; on wrap, digit index increments 0,1,2,3,0.
REQ-018 an = all ones while prescaler < BLANK_CYC, otherwise active-low one-hot of digit index.
REQ-019 seg = decoded selected display digit; a blanked digit is driven with BCD code 4'hF (decoder yields 7'b111_1111).
REQ-020 Scanning shall be independent of conversion; a commit mid-slot updates seg immediately.

Reset
REQ-021 rst_n low shall force: state IDLE, busy 0, prescaler 0, digit index 0, all display/tens/remainder registers 0.
REQ-022 During reset with BLANK_CYC >= 1: an = 4'b1111, seg = 7'b000_0001 (digit 0).
REQ-023 Reset asserted mid-conversion shall abort it; no commit occurs after release.

Configuration
REQ-024 Macro SEG7_ZERO_BLANK_EN: when defined, a tens digit whose value is 0 shall be blanked (REQ-019); when undefined, all four digits always show their value, including a leading 0.

Structure
REQ-025 Shared package seg7_pkg shall hold: the FSM state typedef, the BLANK_BCD constant (4'hF), the saturation limit (99) and the CONV length (10).
REQ-026 Exactly one sub-module: the existing combinational decoder led7thanh_anode, instanced once and fed the muxed BCD digit.

Verification
REQ-027 Reset, then run: an cycles 1110,1101,1011,0111, with 1111 for the first BLANK_CYC cycles of each slot; seg = 7'b000_0001 on every digit (macro off).
REQ-028 load with val_a=57, val_b=8 -> busy high 11 cycles; after commit, an[1]/an[0] show 5/7 (7'b010_0100/7'b000_1111), an[3]/an[2] show 0/8; with SEG7_ZERO_BLANK_EN, an[3] slot seg = 7'b111_1111.
REQ-029 load val_a=120, val_b=99 -> both channels display 99.
REQ-030 load val_a=30, then load val_a=64 four cycles later -> busy stays high 11 cycles after the second load; 30 is never displayed; 64 is displayed.
REQ-031 Assert rst_n low at CONV cycle 5 after load val_a=42 -> after release the display still shows 00 and busy = 0.
REQ-032 SCAN_DIV=4, BLANK_CYC=0 -> anodes advance every 4 cycles and never all go off.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-road 7-segment scan controller.
// Optional build macro: SEG7_ZERO_BLANK_EN (see seg7_scan_ctrl).
package seg7_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_e;

  localparam logic [3:0] BLANK_BCD = 4'hF;
  localparam logic [6:0] SAT_MAX   = 7'd99;
  localparam logic [3:0] CONV_LEN  = 4'd10;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

endpackage

// File: rtl/led7thanh_anode.sv
// BCD to active-low abcdefg decoder; codes 10..15 drive all segments off.
module led7thanh_anode (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b111_1111;
    unique case (bcd_i)
      4'd0: seg_o = 7'b000_0001;
      4'd1: seg_o = 7'b100_1111;
      4'd2: seg_o = 7'b001_0010;
      4'd3: seg_o = 7'b000_0110;
      4'd4: seg_o = 7'b100_1100;
      4'd5: seg_o = 7'b010_0100;
      4'd6: seg_o = 7'b010_0000;
      4'd7: seg_o = 7'b000_1111;
      4'd8: seg_o = 7'b000_0000;
      4'd9: seg_o = 7'b000_0100;
      default: seg_o = 7'b111_1111;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-road countdown display: binary->BCD by repeated subtraction, 4-digit scan.
// Define SEG7_ZERO_BLANK_EN to blank tens digits that read 0.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] val_a,
  input  logic [6:0] val_b,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int PW = $clog2(SCAN_DIV);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] rem_a_q, rem_a_d, rem_b_q, rem_b_d;
  logic [3:0] ten_a_q, ten_a_d, ten_b_q, ten_b_d;
  logic [3:0] da_t_q, da_t_d, da_u_q, da_u_d;
  logic [3:0] db_t_q, db_t_d, db_u_q, db_u_d;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    bcd;
  logic          blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_a_q <= '0;
      rem_b_q <= '0;
      ten_a_q <= '0;
      ten_b_q <= '0;
      da_t_q  <= '0;
      da_u_q  <= '0;
      db_t_q  <= '0;
      db_u_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_a_q <= rem_a_d;
      rem_b_q <= rem_b_d;
      ten_a_q <= ten_a_d;
      ten_b_q <= ten_b_d;
      da_t_q  <= da_t_d;
      da_u_q  <= da_u_d;
      db_t_q  <= db_t_d;
      db_u_q  <= db_u_d;
    end
  end

  // A new load always wins, restarting any conversion in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_a_d = rem_a_q;
    rem_b_d = rem_b_q;
    ten_a_d = ten_a_q;
    ten_b_d = ten_b_q;
    da_t_d  = da_t_q;
    da_u_d  = da_u_q;
    db_t_d  = db_t_q;
    db_u_d  = db_u_q;
    if (load) begin
      state_d = S_CONV;
      cnt_d   = '0;
      rem_a_d = sat99(val_a);
      rem_b_d = sat99(val_b);
      ten_a_d = '0;
      ten_b_d = '0;
    end else begin
      unique case (state_q)
        S_CONV: begin
          if (rem_a_q >= 7'd10) begin
            rem_a_d = rem_a_q - 7'd10;
            ten_a_d = ten_a_q + 4'd1;
          end
          if (rem_b_q >= 7'd10) begin
            rem_b_d = rem_b_q - 7'd10;
            ten_b_d = ten_b_q + 4'd1;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CONV_LEN - 4'd1) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          da_t_d  = ten_a_q;
          da_u_d  = rem_a_q[3:0];
          db_t_d  = ten_b_q;
          db_u_d  = rem_b_q[3:0];
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Written as p+1 <= N so BLANK_CYC=0 does not become an unsigned < 0 test.
  assign blank = (32'(presc_q) + 32'd1) <= 32'(BLANK_CYC);

  always_comb begin
    an = 4'b1111;
    if (!blank) an = ~(4'b0001 << idx_q);
  end

  always_comb begin
    bcd = da_u_q;
    unique case (idx_q)
      2'd0: bcd = da_u_q;
      2'd1: bcd = da_t_q;
      2'd2: bcd = db_u_q;
      2'd3: bcd = db_t_q;
      default: bcd = da_u_q;
    endcase
`ifdef SEG7_ZERO_BLANK_EN
    if (idx_q[0] && (bcd == 4'd0)) bcd = BLANK_BCD;
`endif
  end

  led7thanh_anode u_dec (
    .bcd_i(bcd),
    .seg_o(seg)
  );

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed + random bench for seg7_scan_ctrl against a cycle-count reference model.
module tb_seg7_scan_ctrl;

  localparam int DIV  = 8;
  localparam int BLK  = 2;
  localparam int DIV2 = 4;
  localparam int BLK2 = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] val_a = '0;
  logic [6:0] val_b = '0;
  logic       busy, busy2;
  logic [6:0] seg, seg2;
  logic [3:0] an, an2;

  int total = 0;
  int bad = 0;

  // model: edges since reset release, pending-commit countdown, values
  int t = 0;
  int pend = 0;
  int pa = 0, pb = 0;
  int da = 0, db = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .val_a(val_a), .val_b(val_b),
    .busy(busy), .seg(seg), .an(an)
  );

  seg7_scan_ctrl #(.SCAN_DIV(DIV2), .BLANK_CYC(BLK2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .val_a(val_a), .val_b(val_b),
    .busy(busy2), .seg(seg2), .an(an2)
  );

  function automatic logic [6:0] dec(int d);
    case (d)
      0: return 7'b000_0001;
      1: return 7'b100_1111;
      2: return 7'b001_0010;
      3: return 7'b000_0110;
      4: return 7'b100_1100;
      5: return 7'b010_0100;
      6: return 7'b010_0000;
      7: return 7'b000_1111;
      8: return 7'b000_0000;
      9: return 7'b000_0100;
      default: return 7'b111_1111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int div);
    int idx;
    int d;
    idx = (t / div) % 4;
    case (idx)
      0: d = da % 10;
      1: d = da / 10;
      2: d = db % 10;
      default: d = db / 10;
    endcase
`ifdef SEG7_ZERO_BLANK_EN
    if ((idx % 2) == 1 && d == 0) return 7'b111_1111;
`endif
    return dec(d);
  endfunction

  function automatic logic [3:0] exp_an(int div, int blk);
    int idx;
    idx = (t / div) % 4;
    if ((t % div) < blk) return 4'b1111;
    return ~(4'b0001 << idx);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(pend > 0));
    chk("an", 32'(an), 32'(exp_an(DIV, BLK)));
    chk("seg", 32'(seg), 32'(exp_seg(DIV)));
    chk("busy2", 32'(busy2), 32'(pend > 0));
    chk("an2", 32'(an2), 32'(exp_an(DIV2, BLK2)));
    chk("seg2", 32'(seg2), 32'(exp_seg(DIV2)));
  endtask

  task automatic step(bit ld, int a, int b);
    @(negedge clk);
    load  = ld;
    val_a = 7'(a);
    val_b = 7'(b);
    @(posedge clk);
    t++;
    if (ld) begin
      pend = 11;
      pa = (a > 99) ? 99 : a;
      pb = (b > 99) ? 99 : b;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        da = pa;
        db = pb;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  task automatic do_reset(int hold);
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    t = 0;
    pend = 0;
    da = 0;
    db = 0;
    #1;
    check_all();
    repeat (hold) @(negedge clk);
    #1;
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    idle(2 * 4 * DIV);

    step(1'b1, 57, 8);
    idle(40);

    step(1'b1, 120, 99);
    idle(40);

    step(1'b1, 30, 11);
    idle(3);
    step(1'b1, 64, 5);
    idle(40);

    step(1'b1, 42, 0);
    idle(5);
    do_reset(2);
    idle(40);

    repeat (80) begin
      step(1'b1, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      idle(int'($urandom_range(0, 14)));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
